mem_ctrl: RTL and testbench

Memory-stage controller for the 5-stage RISC-V core. It decodes the load/store held in the EX/MEM pipeline register and runs one data-memory transaction per instruction over a req/ack bus. It stalls the pipeline until the transaction completes, aligns and extends load data for the MEM/WB register, and reports bus timeouts.

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_align.sv | 48 ++++
 rtl/mem_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared opcodes, width codes, FSM states and decode helpers for mem_ctrl
// The optional trap build is selected with the MEM_MISALIGN_TRAP_EN macro.
package mem_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic valid, input logic [6:0] opcode,
                                     input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    if (opcode == OP_LOAD)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    else if (opcode == OP_STORE)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return valid & legal;
  endfunction

  // funct3[1:0] carries the access size for both signed and unsigned loads.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return ((funct3[1:0] == 2'b01) && off[0]) || ((funct3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-enable generation, store lane replication and load extraction
// Purely combinational; misaligned accesses are clipped to the containing word.
module mem_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [3:0]  mask;
  logic [31:0] shifted;

  always_comb begin
    mask      = 4'b1111;
    wdata_rep = st_data;
    case (st_size)
      2'b00: begin
        mask      = 4'b0001;
        wdata_rep = {4{st_data[7:0]}};
      end
      2'b01: begin
        mask      = 4'b0011;
        wdata_rep = {2{st_data[15:0]}};
      end
      default: ;
    endcase
    be = mask << st_off;
  end

  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - MEM-stage load/store controller: req/ack bus, pipeline stall, timeout
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of clipping them.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  localparam int CW = $clog2(TIMEOUT);

  state_t        state, nstate;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic          mem_op, mis, expire, busy;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c, ld_ext;

  assign mem_op = is_mem_op(valid_i, opcode_i, funct3_i);
  assign busy   = (state == ST_BUSY);
  // Ack in the final cycle beats the timeout.
  assign expire = (cnt == CW'(TIMEOUT - 1)) && !dmem_ack_i;

  mem_align u_align (
    .st_size   (funct3_i[1:0]),
    .st_off    (addr_i[1:0]),
    .st_data   (wdata_i),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .ld_funct3 (f3_q),
    .ld_off    (addr_q[1:0]),
    .rdata     (dmem_rdata_i),
    .ld_data   (ld_ext)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign mis = is_misaligned(funct3_i, addr_i[1:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= (state == ST_IDLE) && mem_op && mis;
  end
  assign misalign_o = misalign_q;
`else
  assign mis        = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    nstate  = state;
    stall_o = 1'b0;
    case (state)
      ST_IDLE: if (mem_op) begin
        stall_o = 1'b1;
        nstate  = mis ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (dmem_ack_i || expire) nstate = ST_DONE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      state        <= nstate;
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state)
        ST_IDLE: if (mem_op) begin
          addr_q  <= addr_i;
          wdata_q <= wdata_c;
          be_q    <= be_c;
          f3_q    <= funct3_i;
          we_q    <= (opcode_i == OP_STORE);
          cnt     <= '0;
        end
        ST_BUSY: begin
          cnt <= cnt + CW'(1);
          if (dmem_ack_i) begin
            if (!we_q) begin
              load_data_o  <= ld_ext;
              load_valid_o <= 1'b1;
            end
          end else if (expire) begin
            load_data_o <= '0;
            bus_err_o   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req_o   = busy;
  assign dmem_we_o    = busy & we_q;
  assign dmem_addr_o  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_be_o    = busy ? be_q : 4'h0;
  assign dmem_wdata_o = busy ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
// Expected values are hand-computed per vector; honours MEM_MISALIGN_TRAP_EN.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] load_data_o;
  logic        load_valid_o, bus_err_o, misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .bus_err_o    (bus_err_o),
    .misalign_o   (misalign_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is at negedge+1. waits < 0 means the bus never acks.
  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input int e_stalls, input int e_reqs,
                        input logic [3:0] e_be, input logic [31:0] e_addr,
                        input logic [31:0] e_wd, input logic e_lv, input logic [31:0] e_ld,
                        input logic e_err, input logic e_mis);
    int stalls = 0;
    int reqs = 0;
    logic done = 1'b0;
    logic [3:0] be_c = '0;
    logic [31:0] addr_c = '0, wd_c = '0;
    logic we_c = 1'b0;
    valid_i = 1'b1; opcode_i = op; funct3_i = f3; addr_i = a; wdata_i = wd;
    dmem_rdata_i = rd;
    #1;
    for (int c = 0; c < 60; c++) begin
      if (stall_o) stalls++;
      if (dmem_req_o) begin
        reqs++;
        be_c = dmem_be_o; addr_c = dmem_addr_o; wd_c = dmem_wdata_o; we_c = dmem_we_o;
        dmem_ack_i = (waits >= 0) && (reqs == waits + 1);
      end else begin
        dmem_ack_i = 1'b0;
      end
      if (!stall_o) begin
        done = 1'b1;
        check_eq({tag, ":load_valid"}, 32'(load_valid_o), 32'(e_lv));
        check_eq({tag, ":bus_err"}, 32'(bus_err_o), 32'(e_err));
        check_eq({tag, ":misalign"}, 32'(misalign_o), 32'(e_mis));
        if (op == OP_LOAD) check_eq({tag, ":load_data"}, load_data_o, e_ld);
        break;
      end
      @(negedge clk); #1;
    end
    valid_i = 1'b0; dmem_ack_i = 1'b0;
    check_eq({tag, ":completed"}, 32'(done), 32'd1);
    check_eq({tag, ":stalls"}, 32'(stalls), 32'(e_stalls));
    check_eq({tag, ":req_cycles"}, 32'(reqs), 32'(e_reqs));
    if (e_reqs > 0) begin
      check_eq({tag, ":be"}, 32'(be_c), 32'(e_be));
      check_eq({tag, ":addr"}, addr_c, e_addr);
      check_eq({tag, ":we"}, 32'(we_c), 32'(op == OP_STORE));
      if (op == OP_STORE) check_eq({tag, ":wdata"}, wd_c, e_wd);
    end
    @(negedge clk); #1;
    check_eq({tag, ":pulse_end"}, {29'h0, load_valid_o, bus_err_o, misalign_o}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; opcode_i = '0; funct3_i = '0; addr_i = '0;
    wdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_outs", {24'h0, stall_o, dmem_req_o, dmem_we_o, load_valid_o,
                            bus_err_o, misalign_o, 2'b00}, 32'h0);
    check_eq("reset_bus", dmem_addr_o | dmem_wdata_o | {28'h0, dmem_be_o} | load_data_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    run_op("sw", OP_STORE, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 0,
           2, 1, 4'b1111, 32'h104, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    run_op("lb", OP_LOAD, F3_B, 32'h203, 32'h0, 32'h80123456, 0,
           2, 1, 4'b1000, 32'h200, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
    run_op("lbu", OP_LOAD, F3_BU, 32'h203, 32'h0, 32'h80123456, 0,
           2, 1, 4'b1000, 32'h200, 32'h0, 1'b1, 32'h00000080, 1'b0, 1'b0);
    run_op("sh", OP_STORE, F3_H, 32'h302, 32'h00001234, 32'h0, 3,
           5, 4, 4'b1100, 32'h300, 32'h12341234, 1'b0, 32'h0, 1'b0, 1'b0);
    run_op("sb", OP_STORE, F3_B, 32'h101, 32'h000000AB, 32'h0, 1,
           3, 2, 4'b0010, 32'h100, 32'hABABABAB, 1'b0, 32'h0, 1'b0, 1'b0);
    run_op("lh", OP_LOAD, F3_H, 32'h202, 32'h0, 32'h80015555, 0,
           2, 1, 4'b1100, 32'h200, 32'h0, 1'b1, 32'hFFFF8001, 1'b0, 1'b0);
    run_op("lhu", OP_LOAD, F3_HU, 32'h202, 32'h0, 32'h80015555, 0,
           2, 1, 4'b1100, 32'h200, 32'h0, 1'b1, 32'h00008001, 1'b0, 1'b0);
    run_op("lw", OP_LOAD, F3_W, 32'h100, 32'h0, 32'hCAFEF00D, 2,
           4, 3, 4'b1111, 32'h100, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    run_op("lw_timeout", OP_LOAD, F3_W, 32'h400, 32'h0, 32'h5A5A5A5A, -1,
           17, 16, 4'b1111, 32'h400, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op("lw_ack16", OP_LOAD, F3_W, 32'h404, 32'h0, 32'h11223344, 15,
           17, 16, 4'b1111, 32'h404, 32'h0, 1'b1, 32'h11223344, 1'b0, 1'b0);
    run_op("illegal_f3", OP_LOAD, 3'b011, 32'h500, 32'h0, 32'h0, 0,
           0, 0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h11223344, 1'b0, 1'b0);
    run_op("sbu_illegal", OP_STORE, F3_BU, 32'h500, 32'h0, 32'h0, 0,
           0, 0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    run_op("lw_mis", OP_LOAD, F3_W, 32'h101, 32'h0, 32'hA1B2C3D4, 0,
           1, 0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h11223344, 1'b0, 1'b1);
`else
    run_op("lw_mis", OP_LOAD, F3_W, 32'h101, 32'h0, 32'hA1B2C3D4, 0,
           2, 1, 4'b1110, 32'h100, 32'h0, 1'b1, 32'h00A1B2C3, 1'b0, 1'b0);
`endif

    // Ack while idle must not start anything.
    dmem_ack_i = 1'b1;
    @(negedge clk); #1;
    check_eq("idle_ack", {30'h0, dmem_req_o, load_valid_o}, 32'h0);
    dmem_ack_i = 1'b0;

    // Reset in the middle of a transaction.
    valid_i = 1'b1; opcode_i = OP_LOAD; funct3_i = F3_W; addr_i = 32'h600;
    @(negedge clk); #1;
    check_eq("pre_rst_req", 32'(dmem_req_o), 32'd1);
    rst_n = 1'b0; valid_i = 1'b0;
    #1;
    check_eq("rst_busy_drop", {29'h0, dmem_req_o, stall_o, dmem_we_o}, 32'h0);
    check_eq("rst_busy_bus", dmem_addr_o | {28'h0, dmem_be_o} | load_data_o, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("post_rst_idle", {30'h0, dmem_req_o, stall_o}, 32'h0);
    run_op("post_rst_lw", OP_LOAD, F3_W, 32'h700, 32'h0, 32'h0BADF00D, 0,
           2, 1, 4'b1111, 32'h700, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
